// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : div_pkg
//  Description : Shared types and helpers for the iterative divider and its
//                32-bit carry-lookahead subtractor.
//                - div_state_t  : divider controller states
//                - DIV_WIDTH    : operand width (fixed at 32)
//                - DIV_CNT_W    : iteration counter width
//                - cla4_carry() : carries into the four bits of a 4-bit
//                                 lookahead group
//  Revision    : 1.0  initial release
// ============================================================================
package div_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = 5;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

    // Carries into bits 0..3 of a 4-bit group. Only the low three generate /
    // propagate terms feed these carries; bit 3's terms belong to the group
    // generate/propagate, which the caller forms separately.
    function automatic logic [3:0] cla4_carry(
        input logic [2:0] g,
        input logic [2:0] p,
        input logic       c0
    );
        logic [3:0] c;
        c[0] = c0;
        c[1] = g[0] | (p[0] & c0);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & c0);
        return c;
    endfunction

endpackage : div_pkg
`default_nettype wire

// File: rtl/cla.sv
`default_nettype none
// ============================================================================
//  Module      : cla
//  Description : 32-bit combinational carry-lookahead adder, no carry-out.
//                Two-level lookahead: 4-bit groups, groups chained through
//                group generate/propagate terms.
//  Ports       : a_i   [31:0] in  addend A
//                b_i   [31:0] in  addend B
//                cin_i        in  carry in
//                sum_o [31:0] out A + B + cin (mod 2^32)
//  Revision    : 1.0  initial release
// ============================================================================
module cla
    import div_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        cin_i,
    output logic [31:0] sum_o
);

    // gen[31] would only feed the carry out of the top group, which this
    // adder does not produce, so it is never formed.
    logic [30:0] gen;
    logic [31:0] prop;
    logic [31:0] carry;
    logic [7:0]  grp_cin;
    logic [6:0]  grp_g;
    logic [6:0]  grp_p;

    assign gen        = a_i[30:0] & b_i[30:0];
    assign prop       = a_i ^ b_i;
    assign grp_cin[0] = cin_i;

    for (genvar k = 0; k < 8; k++) begin : g_grp
        assign carry[4*k +: 4] = cla4_carry(gen[4*k +: 3], prop[4*k +: 3], grp_cin[k]);

        // Group terms are only needed to feed the next group.
        if (k < 7) begin : g_lookahead
            assign grp_g[k] = gen[4*k+3]
                            | (prop[4*k+3] & gen[4*k+2])
                            | (prop[4*k+3] & prop[4*k+2] & gen[4*k+1])
                            | (prop[4*k+3] & prop[4*k+2] & prop[4*k+1] & gen[4*k]);
            assign grp_p[k]     = &prop[4*k +: 4];
            assign grp_cin[k+1] = grp_g[k] | (grp_p[k] & grp_cin[k]);
        end
    end

    assign sum_o = prop ^ carry;

endmodule : cla
`default_nettype wire

// File: rtl/div_iter.sv
`default_nettype none
// ============================================================================
//  Module      : div_iter
//  Description : Multi-cycle 32-bit unsigned restoring divider, one quotient
//                bit per cycle, using a single cla instance as subtractor.
//                Valid/ready on both sides; a tag rides along for writeback.
//  Ports       : clk          in   clock
//                rst_n        in   asynchronous active-low reset
//                in_valid     in   request valid
//                in_ready     out  high only when idle
//                in_dividend  in   [WIDTH-1:0] dividend
//                in_divisor   in   [WIDTH-1:0] divisor
//                in_tag       in   [TAG_W-1:0] opaque tag
//                out_valid    out  result valid, held until out_ready
//                out_ready    in   consumer accepts result
//                out_quot     out  [WIDTH-1:0] quotient
//                out_rem      out  [WIDTH-1:0] remainder
//                out_tag      out  [TAG_W-1:0] tag of the request
//  Revision    : 1.0  initial release
// ============================================================================
module div_iter
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_dividend,
    input  logic [WIDTH-1:0] in_divisor,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_quot,
    output logic [WIDTH-1:0] out_rem,
    output logic [TAG_W-1:0] out_tag
);

    localparam logic [DIV_CNT_W-1:0] LAST_ITER = DIV_CNT_W'(WIDTH - 1);

    div_state_t           state_q;
    logic [DIV_CNT_W-1:0] count_q;
    logic [WIDTH-1:0]     rem_q;
    logic [WIDTH-1:0]     quo_q;
    logic [WIDTH-1:0]     divisor_q;
    logic [TAG_W-1:0]     tag_q;

    logic [WIDTH-1:0]     shifted;
    logic [WIDTH-1:0]     divisor_n;
    logic [WIDTH-1:0]     diff;
    logic                 c31;
    logic                 cout;
    logic                 ge;
    logic [WIDTH-1:0]     rem_d;
    logic [WIDTH-1:0]     quo_d;

    // Partial remainder shifted left, pulling in the next dividend bit from
    // the top of the quotient register (dividend bits drain out as quotient
    // bits shift in).
    assign shifted   = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
    assign divisor_n = ~divisor_q;

    cla u_cla (
        .a_i   (shifted),
        .b_i   (divisor_n),
        .cin_i (1'b1),
        .sum_o (diff)
    );

    // The adder has no carry out; recover the carry into bit 31 from the sum
    // bit, then form the carry out of bit 31. A carry out means shifted >=
    // divisor. The bit shifted out of rem_q makes the true 33-bit value
    // exceed any divisor, so it forces a subtract as well.
    assign c31   = diff[WIDTH-1] ^ shifted[WIDTH-1] ^ divisor_n[WIDTH-1];
    assign cout  = (shifted[WIDTH-1] & divisor_n[WIDTH-1])
                 | ((shifted[WIDTH-1] ^ divisor_n[WIDTH-1]) & c31);
    assign ge    = rem_q[WIDTH-1] | cout;
    assign rem_d = ge ? diff : shifted;
    assign quo_d = {quo_q[WIDTH-2:0], ge};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= DIV_IDLE;
            count_q   <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            divisor_q <= '0;
            tag_q     <= '0;
        end else begin
            case (state_q)
                DIV_IDLE: begin
                    if (in_valid) begin
                        divisor_q <= in_divisor;
                        tag_q     <= in_tag;
                        count_q   <= '0;
                        if (in_divisor == '0) begin
                            // Divide by zero: all-ones quotient, dividend as
                            // remainder, no iterations.
                            quo_q   <= '1;
                            rem_q   <= in_dividend;
                            state_q <= DIV_DONE;
                        end else begin
                            quo_q   <= in_dividend;
                            rem_q   <= '0;
                            state_q <= DIV_BUSY;
                        end
                    end
                end
                DIV_BUSY: begin
                    rem_q   <= rem_d;
                    quo_q   <= quo_d;
                    count_q <= count_q + 1'b1;
                    if (count_q == LAST_ITER) begin
                        state_q <= DIV_DONE;
                    end
                end
                DIV_DONE: begin
                    if (out_ready) begin
                        state_q <= DIV_IDLE;
                    end
                end
                default: begin
                    state_q <= DIV_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == DIV_IDLE);
    assign out_valid = (state_q == DIV_DONE);
    assign out_quot  = quo_q;
    assign out_rem   = rem_q;
    assign out_tag   = tag_q;

endmodule : div_iter
`default_nettype wire

// File: tb/tb_div_iter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_div_iter
//  Description : Self-checking bench for div_iter: directed vector table,
//                output hold / ignored-request sequence, mid-operation reset,
//                and randomized back-to-back traffic against an arithmetic
//                reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_div_iter;

    localparam int NRAND     = 1200;
    localparam int MAX_WAIT  = 200;
    localparam int RAND_CYCS = 90000;

    logic        clk         = 1'b0;
    logic        rst_n       = 1'b0;
    logic        in_valid    = 1'b0;
    logic [31:0] in_dividend = '0;
    logic [31:0] in_divisor  = '0;
    logic [4:0]  in_tag      = '0;
    logic        out_ready   = 1'b0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_quot;
    logic [31:0] out_rem;
    logic [4:0]  out_tag;

    int checks = 0;
    int errors = 0;

    div_iter #(.WIDTH(32), .TAG_W(5)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_dividend (in_dividend),
        .in_divisor  (in_divisor),
        .in_tag      (in_tag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_quot    (out_quot),
        .out_rem     (out_rem),
        .out_tag     (out_tag)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Request one division and collect its result. lat counts clock edges
    // from the accept edge until out_valid is seen (0 = valid right after
    // the accept edge).
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag,
                          output logic [31:0] q, output logic [31:0] r, output logic [4:0] t,
                          output int lat, output bit ok);
        int n;
        ok  = 1'b0;
        q   = '0;
        r   = '0;
        t   = '0;
        lat = 0;
        n   = 0;
        @(negedge clk);
        while (!in_ready && n < MAX_WAIT) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) return;
        in_valid    = 1'b1;
        in_dividend = a;
        in_divisor  = b;
        in_tag      = tag;
        @(posedge clk);
        #1;
        // Scramble inputs: only the accept-edge values may matter.
        in_valid    = 1'b0;
        in_dividend = $urandom;
        in_divisor  = $urandom;
        in_tag      = 5'($urandom);
        while (!out_valid && lat < MAX_WAIT) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!out_valid) return;
        q  = out_quot;
        r  = out_rem;
        t  = out_tag;
        ok = 1'b1;
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  tag;
        logic [31:0] q;
        logic [31:0] r;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  tag;
    } req_t;

    vec_t vecs[10];
    req_t pend[$];

    initial begin
        logic [31:0] q, r;
        logic [4:0]  t;
        int          lat;
        bit          ok;
        int          accepts, resps, cyc;
        req_t        rq;
        logic [31:0] eq, er;

        vecs[0] = '{a: 32'd100,        b: 32'd7,          tag: 5'd3,  q: 32'd14,         r: 32'd2,          lat: 32};
        vecs[1] = '{a: 32'hFFFF_FFFF,  b: 32'd1,          tag: 5'd1,  q: 32'hFFFF_FFFF,  r: 32'd0,          lat: 32};
        vecs[2] = '{a: 32'h8000_0000,  b: 32'hFFFF_FFFF,  tag: 5'd2,  q: 32'd0,          r: 32'h8000_0000,  lat: 32};
        vecs[3] = '{a: 32'd12345,      b: 32'd0,          tag: 5'd4,  q: 32'hFFFF_FFFF,  r: 32'd12345,      lat: 0};
        vecs[4] = '{a: 32'd5,          b: 32'd9,          tag: 5'd5,  q: 32'd0,          r: 32'd5,          lat: 32};
        vecs[5] = '{a: 32'd0,          b: 32'd5,          tag: 5'd6,  q: 32'd0,          r: 32'd0,          lat: 32};
        vecs[6] = '{a: 32'hFFFF_FFFF,  b: 32'hFFFF_FFFF,  tag: 5'd31, q: 32'd1,          r: 32'd0,          lat: 32};
        vecs[7] = '{a: 32'd1000000,    b: 32'd3,          tag: 5'd17, q: 32'd333333,     r: 32'd1,          lat: 32};
        vecs[8] = '{a: 32'hFFFF_FFFF,  b: 32'h8000_0000,  tag: 5'd8,  q: 32'd1,          r: 32'h7FFF_FFFF,  lat: 32};
        vecs[9] = '{a: 32'd0,          b: 32'd0,          tag: 5'd0,  q: 32'hFFFF_FFFF,  r: 32'd0,          lat: 0};

        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_quot",  64'(out_quot),  64'd0);
        check("rst_out_rem",   64'(out_rem),   64'd0);
        check("rst_out_tag",   64'(out_tag),   64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);

        // ---------------- directed vector table ----------------
        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].tag, q, r, t, lat, ok);
            check($sformatf("vec%0d_done", i), 64'(ok),  64'd1);
            check($sformatf("vec%0d_quot", i), 64'(q),   64'(vecs[i].q));
            check($sformatf("vec%0d_rem",  i), 64'(r),   64'(vecs[i].r));
            check($sformatf("vec%0d_tag",  i), 64'(t),   64'(vecs[i].tag));
            check($sformatf("vec%0d_lat",  i), 64'(lat), 64'(vecs[i].lat));
        end

        // ---------------- hold in DONE, requests ignored ----------------
        @(negedge clk);
        in_valid = 1'b1; in_dividend = 32'd100; in_divisor = 32'd7; in_tag = 5'd9;
        @(posedge clk);
        #1;
        lat = 0;
        while (!out_valid && lat < MAX_WAIT) begin
            @(negedge clk);
            // Competing request held high the whole time; must never be taken.
            in_valid = 1'b1; in_dividend = 32'd77; in_divisor = 32'd0; in_tag = 5'd22;
            @(posedge clk);
            #1;
            lat++;
        end
        check("hold_lat", 64'(lat), 64'd32);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("hold_out_valid", 64'(out_valid), 64'd1);
            check("hold_in_ready",  64'(in_ready),  64'd0);
            check("hold_quot",      64'(out_quot),  64'd14);
            check("hold_rem",       64'(out_rem),   64'd2);
            check("hold_tag",       64'(out_tag),   64'd9);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("release_out_valid", 64'(out_valid), 64'd0);
        check("release_in_ready",  64'(in_ready),  64'd1);
        run_op(32'd1000, 32'd10, 5'd12, q, r, t, lat, ok);
        check("after_hold_done", 64'(ok), 64'd1);
        check("after_hold_quot", 64'(q),  64'd100);
        check("after_hold_rem",  64'(r),  64'd0);
        check("after_hold_tag",  64'(t),  64'd12);

        // ---------------- reset in the middle of BUSY ----------------
        @(negedge clk);
        in_valid = 1'b1; in_dividend = 32'hFFFF_FFFF; in_divisor = 32'd3; in_tag = 5'd19;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (15) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_quot",      64'(out_quot),  64'd0);
        check("midrst_rem",       64'(out_rem),   64'd0);
        check("midrst_tag",       64'(out_tag),   64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid) break;
        end
        check("midrst_no_output", 64'(out_valid), 64'd0);
        run_op(32'd5, 32'd9, 5'd7, q, r, t, lat, ok);
        check("midrst_next_done", 64'(ok),  64'd1);
        check("midrst_next_quot", 64'(q),   64'd0);
        check("midrst_next_rem",  64'(r),   64'd5);
        check("midrst_next_lat",  64'(lat), 64'd32);

        // ---------------- randomized back-to-back traffic ----------------
        accepts = 0;
        resps   = 0;
        cyc     = 0;
        while (resps < NRAND && cyc < RAND_CYCS) begin
            @(negedge clk);
            cyc++;
            out_ready = ($urandom_range(0, 3) != 0);
            if (out_valid && out_ready) begin
                if (pend.size() == 0) begin
                    check("rand_unexpected_resp", 64'(out_valid), 64'd0);
                end else begin
                    rq = pend.pop_front();
                    if (rq.b == 32'd0) begin
                        eq = 32'hFFFF_FFFF;
                        er = rq.a;
                    end else begin
                        eq = rq.a / rq.b;
                        er = rq.a % rq.b;
                    end
                    check("rand_quot", 64'(out_quot), 64'(eq));
                    check("rand_rem",  64'(out_rem),  64'(er));
                    check("rand_tag",  64'(out_tag),  64'(rq.tag));
                end
                resps++;
            end
            if (in_ready && accepts < NRAND) begin
                rq.a = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
                case ($urandom_range(0, 7))
                    0:       rq.b = 32'd1;
                    1:       rq.b = 32'h8000_0000;
                    2:       rq.b = 32'hFFFF_FFFF;
                    3:       rq.b = 32'd0;
                    4:       rq.b = 32'($urandom_range(1, 15));
                    5:       rq.b = 32'($urandom) >> $urandom_range(0, 31);
                    default: rq.b = 32'($urandom);
                endcase
                rq.tag      = 5'($urandom);
                in_valid    = 1'b1;
                in_dividend = rq.a;
                in_divisor  = rq.b;
                in_tag      = rq.tag;
                pend.push_back(rq);
                accepts++;
            end else begin
                // Noise on the request side while busy; must be ignored.
                in_valid    = in_ready ? 1'b0 : 1'($urandom);
                in_dividend = $urandom;
                in_divisor  = $urandom_range(0, 1) == 0 ? 32'd0 : 32'($urandom);
                in_tag      = 5'($urandom);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("rand_resp_count",   64'(resps),       64'(NRAND));
        check("rand_accept_count", 64'(accepts),     64'(resps));
        check("rand_pending",      64'(pend.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_div_iter
`default_nettype wire
